multicycle_control: RTL and testbench

- Moore control FSM for the multi-cycle MIPS datapath.
- Drives every select and write-enable of the datapath blocks: register WE, 4:1 mux selects, PC source and ALU source selects.
- Takes the opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Keeps a sticky illegal-opcode flag and a retired-instruction counter for bench and debug visibility.

---
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Decodes IR opcode into per-state datapath selects and write enables.
//
// Ports:
//   clk, clr          clock, async active-high reset
//   opcode            IR[31:26], used in DECODE and MEMADDR only
//   PCWrite..PCSource datapath controls, pure decode of state
//   state             current state code
//   illegal           sticky unknown-opcode flag
//   instr_count       retired-instruction counter (wraps)
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RCOMP    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IDLE     = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)
          state_d = S_MEMADDR;
        else if (opcode == OP_RTYPE)
          state_d = S_EXEC;
        else if (opcode == OP_BEQ)
          state_d = S_BRANCH;
        else if (opcode == OP_J)
          state_d = S_JUMP;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADDR:
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXEC:    state_d = S_RCOMP;
      default:   state_d = S_FETCH;
    endcase
  end

  // Only the final state of a legal instruction retires it.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      S_MEMWB, S_MEMWRITE, S_RCOMP,
      S_BRANCH, S_JUMP: retire = 1'b1;
      default:          retire = 1'b0;
    endcase
    cnt_d = cnt_q + (retire ? CNT_W'(1) : '0);
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control.
// Expected state walks and controls come from per-opcode tables.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic        MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_cnt;
  logic        m_ill;
  int          seq[$];

  multicycle_control dut (
    .clk(clk), .clr(clr), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,
  //  IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] ctl_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
            MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSource};
  endfunction

  function automatic logic [15:0] ctl_exp(input int s);
    logic pw, pwc, iord, mr, mw, m2r, irw, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, pwc, iord, mr, mw, m2r, irw, rd, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      0: begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin sa = 1; op = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      9: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, m2r, irw, rd, rw, sa,
            sb, op, ps};
  endfunction

  // Fills seq with the expected state walk; returns legality.
  function automatic bit build_seq(input logic [5:0] op);
    seq = {0, 1};
    case (op)
      6'b100011: begin seq.push_back(2); seq.push_back(3);
                       seq.push_back(4); return 1; end
      6'b101011: begin seq.push_back(2); seq.push_back(5);
                       return 1; end
      6'b000000: begin seq.push_back(6); seq.push_back(7);
                       return 1; end
      6'b000100: begin seq.push_back(8); return 1; end
      6'b000010: begin seq.push_back(9); return 1; end
      default:   return 0;
    endcase
  endfunction

  // Entered just after the posedge into FETCH.
  task automatic run_instr(input logic [5:0] op, input string nm);
    bit legal;
    legal = build_seq(op);
    @(negedge clk);
    opcode = op;
    check({nm, "_cnt_in"}, instr_count, m_cnt);
    check({nm, "_ill_in"}, 32'(illegal), 32'(m_ill));
    foreach (seq[i]) begin
      if (i != 0) @(negedge clk);
      check($sformatf("%s_st%0d", nm, i), 32'(state), 32'(seq[i]));
      check($sformatf("%s_ctl%0d", nm, i), 32'(ctl_now()),
            32'(ctl_exp(seq[i])));
      check($sformatf("%s_rw%0d", nm, i),
            32'(MemRead & MemWrite), 32'd0);
      @(posedge clk);
    end
    if (legal) m_cnt = m_cnt + 1;
    else       m_ill = 1'b1;
    #1;
    check({nm, "_cnt_out"}, instr_count, m_cnt);
    check({nm, "_ill_out"}, 32'(illegal), 32'(m_ill));
    check({nm, "_ret_fetch"}, 32'(state), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    m_cnt = 0;
    m_ill = 0;
    check("rst_state", 32'(state), 32'd15);
    check("rst_ctl", 32'(ctl_now()), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    check("rst_cnt", instr_count, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    check("idle_state", 32'(state), 32'd15);
    @(posedge clk);
  endtask

  logic [5:0] ops[5] = '{6'b100011, 6'b101011, 6'b000000,
                         6'b000100, 6'b000010};

  initial begin
    m_cnt = 0;
    m_ill = 0;
    do_reset();
    run_instr(6'b100011, "lw");
    run_instr(6'b101011, "sw");
    run_instr(6'b000000, "rt");
    run_instr(6'b000100, "beq");
    run_instr(6'b000010, "j");
    run_instr(6'b111111, "ill");
    run_instr(6'b100011, "lw2");

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int k;
      k = int'($urandom_range(0, 5));
      op = (k == 5) ? 6'($urandom) : ops[k];
      run_instr(op, "rnd");
    end

    // Clear while MEMWRITE is active.
    @(negedge clk);
    opcode = 6'b101011;
    repeat (3) @(negedge clk);
    check("mw_pre_state", 32'(state), 32'd5);
    check("mw_pre_we", 32'(MemWrite), 32'd1);
    #1 clr = 1'b1;
    #1;
    check("mw_clr_we", 32'(MemWrite), 32'd0);
    check("mw_clr_state", 32'(state), 32'd15);
    check("mw_clr_ill", 32'(illegal), 32'd0);
    check("mw_clr_cnt", instr_count, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    m_cnt = 0;
    m_ill = 0;
    @(posedge clk);

    // Counter wrap.
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    // Still in DECODE path of a J after this posedge is avoided:
    // the forced edge was FETCH, so resync by running from DECODE.
    opcode = 6'b000010;
    @(negedge clk);
    check("wrap_dec", 32'(state), 32'd1);
    check("wrap_pre", instr_count, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wrap_jump", 32'(state), 32'd9);
    @(negedge clk);
    check("wrap_cnt", instr_count, 32'd0);
    check("wrap_fetch", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
